// File: rtl/win_checker_if.sv
// Bus between the win checker and its neighbours: move inputs, board matrices and held results.
// The win_mask signal exists only when WIN_MASK_EN is defined.
interface win_checker_if;
   logic               landed;
   logic               player;
   logic [15:0][15:0]  red;
   logic [15:0][15:0]  green;
   logic               busy;
   logic               done;
   logic               win;
   logic               draw;
   logic               winner;
   logic [3:0]         win_row;
   logic [3:0]         win_col;
   logic [1:0]         win_dir;
`ifdef WIN_MASK_EN
   logic [15:0][15:0]  win_mask;
`endif

   modport slave (
      input  landed, player, red, green,
      output busy, done, win, draw, winner, win_row, win_col, win_dir
`ifdef WIN_MASK_EN
      , output win_mask
`endif
   );

   modport master (
      output landed, player, red, green,
      input  busy, done, win, draw, winner, win_row, win_col, win_dir
`ifdef WIN_MASK_EN
      , input  win_mask
`endif
   );
endinterface

// File: rtl/win_checker.sv
// Post-landing board scan for WIN_LEN-in-a-row of the moving player's colour, one start cell per cycle.
// Define WIN_MASK_EN to add the win_mask output marking the cells of the reported line.
module win_checker #(
   parameter int WIN_LEN = 4
) (
   input  logic          clock,
   input  logic          reset,
   win_checker_if.slave  bus
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SCAN   = 2'd1;
   localparam logic [1:0] ST_REPORT = 2'd2;

   logic [1:0]        r_state;
   logic [7:0]        r_index;
   logic [15:0][15:0] r_own;
   logic [15:0]       r_occ0;
   logic              r_busy;
   logic              r_done;
   logic              r_win;
   logic              r_draw;
   logic              r_winner;
   logic [3:0]        r_win_row;
   logic [3:0]        r_win_col;
   logic [1:0]        r_win_dir;

   logic [3:0]        w_r;
   logic [3:0]        w_c;
   logic              w_fit_h;
   logic              w_fit_v;
   logic              w_fit_a;
   logic [3:0]        w_ok;
   logic              w_hit;
   logic [1:0]        w_dir;

   // cell(r,c) lives at matrix[r][15-c]
   function automatic logic cell_at(input logic [15:0][15:0] b, input logic [3:0] r, input logic [3:0] c);
      cell_at = b[r][4'd15 - c];
   endfunction

   assign w_r = r_index[7:4];
   assign w_c = r_index[3:0];

   // Bounds and per-direction line match for the current start cell; wrapped indices are masked by the fit flags
   always_comb begin
      w_fit_h = (({1'b0, w_c} + 5'(WIN_LEN - 1)) <= 5'd15);
      w_fit_v = (({1'b0, w_r} + 5'(WIN_LEN - 1)) <= 5'd15);
      w_fit_a = (w_c >= 4'(WIN_LEN - 1));
      w_ok    = {w_fit_v & w_fit_a, w_fit_v & w_fit_h, w_fit_v, w_fit_h};
      for (int i = 0; i < WIN_LEN; i++) begin
         w_ok[0] = w_ok[0] & cell_at(r_own, w_r,           w_c + 4'(i));
         w_ok[1] = w_ok[1] & cell_at(r_own, w_r + 4'(i),  w_c);
         w_ok[2] = w_ok[2] & cell_at(r_own, w_r + 4'(i),  w_c + 4'(i));
         w_ok[3] = w_ok[3] & cell_at(r_own, w_r + 4'(i),  w_c - 4'(i));
      end
   end

   // Lowest-numbered hitting direction wins the tie
   always_comb begin
      w_hit = |w_ok;
      if (w_ok[0]) begin
         w_dir = 2'd0;
      end else if (w_ok[1]) begin
         w_dir = 2'd1;
      end else if (w_ok[2]) begin
         w_dir = 2'd2;
      end else begin
         w_dir = 2'd3;
      end
   end

`ifdef WIN_MASK_EN
   logic [15:0][15:0] r_mask;
   logic [15:0][15:0] w_mask;

   // Cells of the line that would be reported from the current start cell
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < WIN_LEN; i++) begin
         case (w_dir)
            2'd0:    w_mask[w_r][4'd15 - (w_c + 4'(i))]          = 1'b1;
            2'd1:    w_mask[w_r + 4'(i)][4'd15 - w_c]            = 1'b1;
            2'd2:    w_mask[w_r + 4'(i)][4'd15 - (w_c + 4'(i))]  = 1'b1;
            default: w_mask[w_r + 4'(i)][4'd15 - (w_c - 4'(i))]  = 1'b1;
         endcase
      end
   end

   // Mask register: cleared on accepted landing, loaded together with win
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_mask <= '0;
      end else if (r_state == ST_IDLE && bus.landed) begin
         r_mask <= '0;
      end else if (r_state == ST_SCAN && w_hit) begin
         r_mask <= w_mask;
      end
   end

   assign bus.win_mask = r_mask;
`endif

   // Control FSM, snapshots and held result registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_index   <= 8'd0;
         r_own     <= '0;
         r_occ0    <= 16'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_win     <= 1'b0;
         r_draw    <= 1'b0;
         r_winner  <= 1'b0;
         r_win_row <= 4'd0;
         r_win_col <= 4'd0;
         r_win_dir <= 2'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.landed) begin
                  r_own     <= bus.player ? bus.green : bus.red;
                  r_occ0    <= bus.red[0] | bus.green[0];
                  r_winner  <= bus.player;
                  r_win     <= 1'b0;
                  r_draw    <= 1'b0;
                  r_win_row <= 4'd0;
                  r_win_col <= 4'd0;
                  r_win_dir <= 2'd0;
                  r_index   <= 8'd0;
                  r_busy    <= 1'b1;
                  r_state   <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (w_hit) begin
                  r_win     <= 1'b1;
                  r_win_row <= w_r;
                  r_win_col <= w_c;
                  r_win_dir <= w_dir;
                  r_busy    <= 1'b0;
                  r_state   <= ST_REPORT;
               end else if (r_index == 8'd255) begin
                  r_draw    <= &r_occ0;
                  r_busy    <= 1'b0;
                  r_state   <= ST_REPORT;
               end else begin
                  r_index   <= r_index + 8'd1;
               end
            end
            ST_REPORT: begin
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.win     = r_win;
   assign bus.draw    = r_draw;
   assign bus.winner  = r_winner;
   assign bus.win_row = r_win_row;
   assign bus.win_col = r_win_col;
   assign bus.win_dir = r_win_dir;

endmodule

// File: tb/tb_win_checker.sv
// Directed bench for win_checker: expected results are queued at each landing and checked when done pulses.
module tb_win_checker;

   logic clock;
   logic reset;
   int   cyc;
   int   n_assert;
   int   n_fail;
   int   e;

   typedef struct {
      logic              win;
      logic              draw;
      logic              winner;
      logic [3:0]        row;
      logic [3:0]        col;
      logic [1:0]        dir;
      int                lat;
      logic [15:0][15:0] mask;
   } exp_t;

   exp_t sb[$];

   win_checker_if bus();

   win_checker #(.WIN_LEN(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [15:0][15:0] mk_mask(input int r, input int c, input int d);
      logic [15:0][15:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) begin
         case (d)
            0:       m[r][15-(c+i)]   = 1'b1;
            1:       m[r+i][15-c]     = 1'b1;
            2:       m[r+i][15-(c+i)] = 1'b1;
            default: m[r+i][15-(c-i)] = 1'b1;
         endcase
      end
      return m;
   endfunction

   task automatic push_exp(input logic w, input logic d, input logic p, input int r, input int c,
                           input int dir, input int lat);
      exp_t x;
      x.win = w; x.draw = d; x.winner = p;
      x.row = 4'(r); x.col = 4'(c); x.dir = 2'(dir); x.lat = lat;
      x.mask = w ? mk_mask(r, c, dir) : '0;
      sb.push_back(x);
   endtask

   task automatic set_red(input int r, input int c);
      bus.red[r][15-c] = 1'b1;
   endtask

   task automatic set_green(input int r, input int c);
      bus.green[r][15-c] = 1'b1;
   endtask

   task automatic clear_board();
      bus.red   = '0;
      bus.green = '0;
   endtask

   // Pulse landed for one cycle; returns the cycle count of the sampling edge
   task automatic pulse_landed(input logic p, output int edge_cyc);
      @(negedge clock);
      bus.landed = 1'b1;
      bus.player = p;
      @(negedge clock);
      bus.landed = 1'b0;
      edge_cyc = cyc;
   endtask

   task automatic expect_quiet(input string tag, input int n);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         seen = seen | (bus.done === 1'b1);
      end
      chk(tag, 32'(seen), 32'd0);
   endtask

   task automatic wait_done(input string tag, input int edge_cyc);
      exp_t x;
      logic got;
      got = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (bus.done === 1'b1) begin
            got = 1'b1;
            break;
         end
         @(negedge clock);
      end
      chk({tag, "_done_seen"}, 32'(got), 32'd1);
      if (sb.size() == 0) begin
         chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      end else begin
         x = sb.pop_front();
         chk({tag, "_latency"}, 32'(cyc - edge_cyc), 32'(x.lat));
         chk({tag, "_win"},     32'(bus.win),     32'(x.win));
         chk({tag, "_draw"},    32'(bus.draw),    32'(x.draw));
         chk({tag, "_winner"},  32'(bus.winner),  32'(x.winner));
         chk({tag, "_busy"},    32'(bus.busy),    32'd0);
         if (x.win) begin
            chk({tag, "_row"}, 32'(bus.win_row), 32'(x.row));
            chk({tag, "_col"}, 32'(bus.win_col), 32'(x.col));
            chk({tag, "_dir"}, 32'(bus.win_dir), 32'(x.dir));
         end else begin
            chk({tag, "_rcd"}, 32'({bus.win_row, bus.win_col, bus.win_dir}), 32'd0);
         end
`ifdef WIN_MASK_EN
         n_assert++;
         assert (bus.win_mask === x.mask) else begin
            n_fail++;
            $error("FAIL %s_mask: observed %0h expected %0h", tag, bus.win_mask, x.mask);
         end
`endif
      end
      @(negedge clock);
      chk({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      cyc      = 0;
      reset    = 1'b0;
      bus.landed = 1'b0;
      bus.player = 1'b0;
      clear_board();

      // Reset state
      repeat (3) @(negedge clock);
      chk("rst_busy",   32'(bus.busy),   32'd0);
      chk("rst_done",   32'(bus.done),   32'd0);
      chk("rst_result", 32'({bus.win, bus.draw, bus.winner, bus.win_row, bus.win_col, bus.win_dir}), 32'd0);
      reset = 1'b1;

      // Reset mid-scan aborts without a done pulse
      pulse_landed(1'b0, e);
      repeat (10) @(negedge clock);
      chk("mid_busy", 32'(bus.busy), 32'd1);
      reset = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_result", 32'({bus.done, bus.win, bus.draw, bus.winner, bus.win_row, bus.win_col, bus.win_dir}), 32'd0);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      expect_quiet("mid_no_done", 300);
      push_exp(1'b0, 1'b0, 1'b0, 0, 0, 0, 257);
      pulse_landed(1'b0, e);
      wait_done("after_rst", e);

      // Vertical win in column 3
      clear_board();
      for (int r = 12; r < 16; r++) set_red(r, 3);
      push_exp(1'b1, 1'b0, 1'b0, 12, 3, 1, 12*16 + 3 + 2);
      pulse_landed(1'b0, e);
      wait_done("vert", e);

      // Horizontal at the right edge must not wrap
      clear_board();
      set_green(15, 13); set_green(15, 14); set_green(15, 15); set_green(14, 0);
      push_exp(1'b0, 1'b0, 1'b1, 0, 0, 0, 257);
      pulse_landed(1'b1, e);
      wait_done("nowrap", e);
      set_green(15, 12);
      push_exp(1'b1, 1'b0, 1'b1, 15, 12, 0, 15*16 + 12 + 2);
      pulse_landed(1'b1, e);
      wait_done("horiz", e);

      // Anti-diagonal alone, then horizontal takes priority at the same start cell
      clear_board();
      set_red(12, 6); set_red(13, 5); set_red(14, 4); set_red(15, 3);
      push_exp(1'b1, 1'b0, 1'b0, 12, 6, 3, 12*16 + 6 + 2);
      pulse_landed(1'b0, e);
      wait_done("anti", e);
      for (int c = 7; c < 10; c++) set_red(12, c);
      push_exp(1'b1, 1'b0, 1'b0, 12, 6, 0, 12*16 + 6 + 2);
      pulse_landed(1'b0, e);
      wait_done("prio", e);

      // Full board of 2x1 blocks with no line of four: draw
      clear_board();
      for (int r = 0; r < 16; r++) begin
         for (int c = 0; c < 16; c++) begin
            if (((r + (c >> 1)) & 1) == 1) set_green(r, c);
            else                           set_red(r, c);
         end
      end
      push_exp(1'b0, 1'b1, 1'b1, 0, 0, 0, 257);
      pulse_landed(1'b1, e);
      wait_done("draw", e);

      // Landed during a scan is ignored; the snapshot hides the board change
      clear_board();
      push_exp(1'b0, 1'b0, 1'b0, 0, 0, 0, 257);
      pulse_landed(1'b0, e);
      repeat (4) @(negedge clock);
      for (int r = 0; r < 4; r++) set_green(r, 0);
      bus.landed = 1'b1;
      bus.player = 1'b1;
      @(negedge clock);
      bus.landed = 1'b0;
      wait_done("ignored", e);
      expect_quiet("ignored_single", 300);
      chk("ignored_sb_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/win_checker.md
Name: win_checker

Overview:
- Downstream of the piece-drop animation stage. Consumes the red/green 16x16 LED matrices and the one-cycle landed pulse.
- After each landing, scans the snapshotted board one cell per cycle for WIN_LEN-in-a-row of the moving player's colour.
- Reports win, draw, or continue to the game-control FSM, which uses the result to switch players or end the game.

Parameters:
- WIN_LEN, 4, number of consecutive same-colour cells that constitute a win (legal range 2..16).

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- landed  input  1  one-cycle pulse: move complete, matrices final
- player  input  1  player who just moved (1 = green, 0 = red), sampled with landed
- red  input  [15:0][15:0]  red matrix, [row][15-column]
- green  input  [15:0][15:0]  green matrix, same indexing
- busy  output  1  high while scanning
- done  output  1  one-cycle pulse: result valid
- win  output  1  held: moving player has a line
- draw  output  1  held: no win and row 0 fully occupied
- winner  output  1  held: player that was checked
- win_row  output  4  held: row of first cell of winning line
- win_col  output  4  held: game column of first cell
- win_dir  output  2  held: 0 horizontal, 1 vertical, 2 diagonal, 3 anti-diagonal

Behaviour:
- Coordinates:
  - cell(r,c) = matrix[r][15-c], with r, c in 0..15.
  - Line cells from start (r,c), i = 0..WIN_LEN-1:
    - dir0: (r, c+i)
    - dir1: (r+i, c)
    - dir2: (r+i, c+i)
    - dir3: (r+i, c-i)
  - A direction is only evaluated when all of its cells are in bounds. No wrap-around across edges.
- Reset (async, reset==0): state IDLE; busy, done, win, draw, winner, win_row, win_col, win_dir all 0; scan index 0; snapshots 0.
- States:
  - IDLE: on landed==1, capture three snapshots: own = player ? green : red; occ = red | green; winner = player. Clear win, draw, win_row, win_col, win_dir. Index <= 0. Go to SCAN.
  - SCAN: busy=1. Each cycle evaluate the start cell at index (r = index[7:4], c = index[3:0]) against the own snapshot.
    - Hit (any direction all ones): record r, c and the lowest-numbered hitting direction; set win=1; go to REPORT.
    - No hit and index==255: set draw = &occ[0]; go to REPORT.
    - Otherwise: index <= index+1.
  - REPORT: done=1 for exactly one cycle, busy=0; go to IDLE. Result outputs hold until the next accepted landed.
- Latency:
  - landed sampled at edge E; start cell k is evaluated in the cycle after edge E+k.
  - Win at index k: done high in the cycle after edge E+k+2.
  - No win: done high in the cycle after edge E+257.
- Scan order is row-major (row 0 first, column 0 first). The reported line is the first hit in that order.
- win and draw are never both 1.
- landed asserted while busy or in REPORT is ignored (no queueing). The snapshot isolates the scan from matrix changes during the scan.
- Reset asserted mid-scan aborts immediately to the reset values; no done pulse.

Optional Feature:
- Macro WIN_MASK_EN adds output win_mask [15:0][15:0], indexed like red/green.
- With WIN_MASK_EN: win_mask is loaded in the same cycle win is set, with exactly the WIN_LEN cells of the reported line set. It is cleared on reset and on each accepted landed. Used to flash the winning line.
- Without WIN_MASK_EN: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-scan: landed on a blank board, then reset=0 at cycle 10 -> all outputs 0 immediately; no done pulse; a landed after reset release is accepted.
- Vertical win: red cells (12..15, column 3), landed with player=0 -> done once, win=1, winner=0, win_row=12, win_col=3, win_dir=1, done in the cycle after edge E+12*16+3+2.
- Horizontal edge/no-wrap: green at row 15, columns 13,14,15 plus row 14 column 0, player=1 -> no win, draw=0, done in the cycle after edge E+257. Then add green (15,12) and landed -> win, win_row=15, win_col=12, win_dir=0.
- Anti-diagonal and priority: red at (12,6),(13,5),(14,4),(15,3) plus (12,6..9) -> reports win_row=12, win_col=6, win_dir=0 (horizontal beats anti-diagonal at the same start cell). With WIN_MASK_EN, mask has exactly those 4 horizontal bits set.
- Draw: full board in a checkerboard of 2x1 blocks with no 4-in-a-row, landed player=1 -> win=0, draw=1, done once.
- Ignored landed: second landed pulse 5 cycles into a scan -> a single done pulse; results reflect the first snapshot only.
